serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial WIDTH-bit subtractor that computes diff = a - b one bit per clock, LSB first. It uses a single full-subtractor cell with a registered borrow fed back each cycle. Operands are loaded on a start pulse and the result appears with a one-cycle done strobe. It sits in the arithmetic datapath as the sequential consumer of the one-bit subtractor cell's diff/borrow outputs, for area-constrained multi-bit subtraction.

Parameters:
WIDTH, 8, operand and result width in bits (legal values 2..32)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  load request; sampled only in IDLE
a  input  WIDTH  minuend; captured on the accepted start edge
b  input  WIDTH  subtrahend; captured on the accepted start edge
busy  output  1  high while bits are being shifted (SHIFT state)
done  output  1  one-cycle strobe; result valid
diff  output  WIDTH  registered result a - b (mod 2^WIDTH)
borrow_out  output  1  final borrow; 1 when a < b as unsigned values

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, diff=0, borrow_out=0; shift registers, internal borrow and bit counter cleared.
- A reset asserted mid-operation aborts immediately. No done is produced, and the outputs return to reset values.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: when start=1 at an edge, load a_sh<=a, b_sh<=b, br<=0, cnt<=0, go to SHIFT. When start=0, stay.
- SHIFT: on each edge, with bits a0=a_sh[0], b0=b_sh[0]:
  - d = a0^b0^br
  - br <= (~a0 & (b0|br)) | (b0 & br)
  - shift d into the result register from the MSB side; shift a_sh and b_sh right by 1
  - cnt <= cnt+1
- SHIFT exit: on the edge where cnt==WIDTH-1, go to DONE. That same edge copies the full result register to diff and the updated borrow to borrow_out, and sets done<=1.
- DONE: lasts exactly one cycle with done=1, then returns to IDLE with done<=0.
- Latency: the start edge is edge 0. Shifts occur on edges 1..WIDTH, and done is high for the cycle following edge WIDTH. Back-to-back ops therefore take WIDTH+2 cycles each.
- busy=1 exactly in SHIFT (WIDTH cycles); 0 in IDLE and DONE.
- diff and borrow_out never show partial results. They hold the previous result until the next done and are unchanged by later start or operand changes.
- start in SHIFT or DONE is ignored, with no queuing. Operand inputs are don't-care outside the accepted start edge.
- Arithmetic is unsigned modulo 2^WIDTH. borrow_out=1 iff a<b; a==b gives diff=0, borrow_out=0.
- cnt width is clog2(WIDTH)+1 bits and must not wrap before WIDTH-1 is reached.

Optional Feature:
SERIAL_SUB_OVERFLOW_EN
- Defined: adds output port ovf (1 bit), registered, reset 0, updated only with diff. ovf is signed two's-complement overflow: (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]), using the captured operand MSBs. It holds until the next done.
- Undefined: port ovf and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, start pulse -> busy high 8 cycles; done one cycle after edge 8; diff=0x1E, borrow_out=0.
- a=0x00, b=0x01 -> diff=0xFF, borrow_out=1. Then a=0x80, b=0x80 -> diff=0x00, borrow_out=0; the previous 0xFF is held until the new done.
- a=0x10, b=0x01 started, start re-pulsed with a=0xFF, b=0x00 at cycle 3 of SHIFT -> second start ignored; diff=0x0F, borrow_out=0, exactly one done.
- Start a=0xF0, b=0x0F, assert rst at cycle 4 of SHIFT (asynchronously, mid-cycle) -> outputs 0 immediately, state IDLE, no done. After release, new op a=0x03, b=0x05 -> diff=0xFE, borrow_out=1.
- SERIAL_SUB_OVERFLOW_EN defined, a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, ovf=1. Then a=0x05, b=0x03 -> diff=0x02, ovf=0.
- Randomised 1000 ops at WIDTH=8 and WIDTH=16 against a model computing (a-b) mod 2^WIDTH and a<b -> zero mismatches; done count equals accepted start count.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b, one bit per clock, LSB first.
// Latency: start edge is edge 0, shifts on edges 1..WIDTH, done high the cycle after edge WIDTH.
// Backpressure: none; start is only sampled in IDLE and is ignored (not queued) otherwise.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   start, a, b      load request and operands (operands captured on the accepted start edge)
//   busy             high while bits are being shifted
//   done             one-cycle strobe, diff/borrow_out freshly updated
//   diff, borrow_out registered result (mod 2^WIDTH) and final borrow (a < b unsigned)
//   ovf              signed overflow flag, present only when SERIAL_SUB_OVERFLOW_EN is defined
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CW-1:0]    cnt;

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic a_msb;
  logic b_msb;
`endif

  // Full-subtractor cell on the current LSBs with the registered borrow.
  logic a0;
  logic b0;
  logic d;
  logic br_next;
  logic last_bit;
  logic [WIDTH-1:0] res_next;

  assign a0       = a_sh[0];
  assign b0       = b_sh[0];
  assign d        = a0 ^ b0 ^ br;
  assign br_next  = (~a0 & (b0 | br)) | (b0 & br);
  assign last_bit = (cnt == CW'(WIDTH - 1));
  // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign res_next = {d, res[WIDTH-1:1]};

  assign busy = (state_q == SHIFT);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand shifters, borrow, counter and the output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh       <= '0;
      b_sh       <= '0;
      res        <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      ovf        <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= 1'b0;
            cnt   <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          res  <= res_next;
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= br_next;
          cnt  <= cnt + 1'b1;
          if (last_bit) begin
            // Outputs only ever take a complete result, never a partial one.
            diff       <= res_next;
            borrow_out <= br_next;
            done       <= 1'b1;
`ifdef SERIAL_SUB_OVERFLOW_EN
            // d is the result MSB on the final shift.
            ovf        <= (a_msb != b_msb) && (d != a_msb);
`endif
          end
        end
        DONE: begin
          done <= 1'b0;
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int start_cnt = 0;
  logic [W-1:0] last_diff = '0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    .ovf        (ovf)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Runs one operation and checks latency, busy length, hold behaviour and the result.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] exp_d, input logic exp_b, input logic exp_o,
                       input string tag);
    int n;
    int busy_cycles;
    logic held;
    @(negedge clk);
    start = 1'b1; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    start_cnt++;
    n = 0; busy_cycles = 0; held = 1'b1;
    while (done !== 1'b1 && n < 4 * W) begin
      if (busy === 1'b1) busy_cycles++;
      if (diff !== last_diff) held = 1'b0;
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, W);
    chk({tag, "_busy"}, busy_cycles, W);
    chk({tag, "_hold"}, {31'd0, held}, 32'd1);
    chk({tag, "_diff"}, {24'd0, diff}, {24'd0, exp_d});
    chk({tag, "_bor"}, {31'd0, borrow_out}, {31'd0, exp_b});
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_o});
`else
    if (exp_o === 1'bx) $display("unexpected x ovf");
`endif
    last_diff = exp_d;
    @(negedge clk);
    chk({tag, "_done_off"}, {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    int n;
    int dc;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] rd;

    #3;
    chk("rst_outs", {21'd0, busy, done, borrow_out, diff}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic directed vectors: a, b, diff, borrow, ovf
    do_op(8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0, "v5a3c");
    do_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, "v0001");
    do_op(8'h80, 8'h80, 8'h00, 1'b0, 1'b0, "v8080");
    do_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "v8001");
    do_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, "v0503");
    do_op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, "vffff");
    do_op(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, "v00ff");

    // Start re-pulsed during SHIFT must be ignored.
    dc = done_cnt;
    @(negedge clk);
    start = 1'b1; a = 8'h10; b = 8'h01;
    @(negedge clk);
    start = 1'b0; start_cnt++;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'h00;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
    chk("restart_diff", {24'd0, diff}, 32'h0F);
    chk("restart_bor", {31'd0, borrow_out}, 32'd0);
    last_diff = 8'h0F;
    repeat (2 * W) @(negedge clk);
    chk("restart_one_done", done_cnt - dc, 1);

    // Asynchronous reset mid-SHIFT aborts the operation.
    dc = done_cnt;
    @(negedge clk);
    start = 1'b1; a = 8'hF0; b = 8'h0F;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_outs", {21'd0, busy, done, borrow_out, diff}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_diff = '0;
    repeat (W + 4) @(negedge clk);
    chk("arst_no_done", done_cnt - dc, 0);
    chk("arst_idle", {31'd0, busy}, 32'd0);
    do_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, "v0305");

    // Model-checked sweep of operand pairs.
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i == 0) begin ra = 8'h7F; rb = 8'h80; end
      rd = ra - rb;
      do_op(ra, rb, rd, ra < rb, (ra[W-1] != rb[W-1]) && (rd[W-1] != ra[W-1]), "rnd");
    end

    chk("done_vs_start", done_cnt, start_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
